// File: rtl/pkt_word_fifo.sv
// Word FIFO behind the packet parser; tags each packet's CRC word as last and counts whole packets.
// Define STORE_FWD_EN to hold words back until their packet is complete (store-and-forward).
module pkt_word_fifo #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned PKT_WORDS    = 11,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

  logic [WIDTH:0]    mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     wr_cnt;
  logic [WIDTH:0]    head;
  logic              wr_en;
  logic              rd_en;
  logic              wr_tag;

  // Pointer MSB separates full from empty, so the difference is the occupancy.
  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == PW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= PW'(AFULL_THRESH));
  assign wr_ready    = !full;

`ifdef STORE_FWD_EN
  assign rd_valid = (pkt_count != '0);
`else
  assign rd_valid = !empty;
`endif

  assign head    = mem[rd_ptr[AW-1:0]];
  assign rd_data = rd_valid ? head[WIDTH-1:0] : '0;
  assign rd_last = rd_valid & head[WIDTH];

  assign wr_en  = wr_valid && wr_ready;
  assign rd_en  = rd_valid && rd_ready;
  assign wr_tag = (wr_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {wr_tag, wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_cnt    <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
        wr_cnt <= wr_tag ? '0 : wr_cnt + CW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en && wr_tag, rd_en && head[WIDTH]})
        2'b10:   pkt_count <= pkt_count + PW'(1);
        2'b01:   pkt_count <= pkt_count - PW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule
